// File: rtl/smm_arbiter_if.sv
// Requester, engine and response signals of the 4x4 matrix-multiply arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface smm_arbiter_if #(
    parameter int DATAWIDTH = 32,
    parameter int NREQ      = 4
);
    localparam int BW  = DATAWIDTH * 16;
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_sel;
    logic [NREQ*BW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [BW-1:0]      eng_a;
    logic [BW-1:0]      eng_b;
    logic               eng_sel;
    logic               eng_load;
    logic [BW-1:0]      eng_c;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [BW-1:0]      rsp_c;
    logic               busy;
    logic [15:0]        done_cnt;

    modport slave (
        input  req_valid, req_sel, req_a, req_b, eng_c, rsp_ready,
        output req_ready, eng_a, eng_b, eng_sel, eng_load,
               rsp_valid, rsp_id, rsp_c, busy, done_cnt
    );

    modport master (
        output req_valid, req_sel, req_a, req_b, eng_c, rsp_ready,
        input  req_ready, eng_a, eng_b, eng_sel, eng_load,
               rsp_valid, rsp_id, rsp_c, busy, done_cnt
    );
endinterface

// File: rtl/smm_arbiter.sv
// Round-robin arbiter feeding a fixed-latency matrix-multiply engine,
// one operation in flight; results held until the consumer accepts them.
module smm_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int NREQ      = 4,
    parameter int LATENCY   = 8
) (
    input  logic         clk,
    input  logic         rst,
    smm_arbiter_if.slave bus
);
    localparam int BW  = DATAWIDTH * 16;
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t                     state;
    logic [IDW-1:0]             ptr;
    logic [CW-1:0]              cnt;
    logic [15:0]                done_cnt;
    logic [BW-1:0]              eng_a, eng_b, rsp_c;
    logic                       eng_sel, eng_load, rsp_valid;
    logic [IDW-1:0]             rsp_id;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][BW-1:0]    a_arr, b_arr;
    logic [IDW-1:0]             win;
    logic                       win_vld;
    logic [IDW:0]               cand;

    assign a_arr = bus.req_a;
    assign b_arr = bus.req_b;

    // Rotating search: first valid requester at or above ptr, wrapping at NREQ.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!win_vld && bus.req_valid[cand[IDW-1:0]]) begin
                win     = cand[IDW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_vld)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            done_cnt  <= '0;
            eng_a     <= '0;
            eng_b     <= '0;
            eng_sel   <= 1'b0;
            eng_load  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
        end else begin
            eng_load <= 1'b0;
            case (state)
                IDLE: if (win_vld) begin
                    eng_a    <= a_arr[win];
                    eng_b    <= b_arr[win];
                    eng_sel  <= bus.req_sel[win];
                    rsp_id   <= win;
                    eng_load <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    cnt   <= CW'(LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_c     <= bus.eng_c;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid <= 1'b0;
                    ptr       <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                    done_cnt  <= done_cnt + 16'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.eng_a     = eng_a;
    assign bus.eng_b     = eng_b;
    assign bus.eng_sel   = eng_sel;
    assign bus.eng_load  = eng_load;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_c     = rsp_c;
    assign bus.busy      = (state != IDLE);
    assign bus.done_cnt  = done_cnt;
endmodule

// File: doc/smm_arbiter.md
SMM_ARBITER -- requirements
Module: smm_arbiter

Interface
- REQ-001: Parameter DATAWIDTH, default 32, element width; BUSWIDTH = DATAWIDTH*16 (one 4x4 matrix bus).
- REQ-002: Parameter NREQ, default 4, number of requesters; legal range 2..8.
- REQ-003: Parameter LATENCY, default 8, cycles from eng_load to valid eng_c; legal value >= 1.
- REQ-004: Clock and reset: one clock; reset is synchronous and active-low.
- REQ-005: clk  in  1  rising-edge clock for all state.
- REQ-006: rst  in  1  synchronous, active-low reset.
- REQ-007: req_valid  in  NREQ  per-requester operation request.
- REQ-008: req_sel  in  NREQ  per-requester engine mode bit.
- REQ-009: req_a, req_b  in  NREQ*BUSWIDTH  operands; requester k occupies bits [k*BUSWIDTH +: BUSWIDTH].
- REQ-010: req_ready  out  NREQ  one-hot accept strobe.
- REQ-011: eng_a, eng_b  out  BUSWIDTH  registered operands to the multiply engine.
- REQ-012: eng_sel  out  1  registered mode bit to the engine.
- REQ-013: eng_load  out  1  single-cycle start pulse to the engine.
- REQ-014: eng_c  in  BUSWIDTH  engine result.
- REQ-015: rsp_valid  out  1  result available.
- REQ-016: rsp_ready  in  1  result consumed.
- REQ-017: rsp_id  out  clog2(NREQ)  index of the requester owning rsp_c.
- REQ-018: rsp_c  out  BUSWIDTH  registered result.
- REQ-019: busy  out  1  high whenever state != IDLE.
- REQ-020: done_cnt  out  16  count of completed operations.

Function
- REQ-021: FSM states are IDLE, LOAD, WAIT and RESP; only one operation is in flight at a time.
- REQ-022: IDLE: winner w is the first k with req_valid[k] set, searching from ptr upward modulo NREQ; req_ready[w] is 1, with all other bits 0; req_ready is all-zero outside IDLE.
- REQ-023: IDLE handshake (req_valid[w] && req_ready[w]): latch req_a[w] to eng_a, req_b[w] to eng_b, req_sel[w] to eng_sel and w to rsp_id, then go to LOAD.
- REQ-024: LOAD: eng_load is 1 for exactly this cycle; the counter loads LATENCY-1; next state is WAIT.
- REQ-025: WAIT: if the counter is 0, capture eng_c into rsp_c and go to RESP; otherwise decrement the counter.
- REQ-026: Timing: with eng_load high in cycle t, eng_c is sampled at the end of cycle t+LATENCY and rsp_valid rises in cycle t+LATENCY+1.
- REQ-027: RESP: rsp_valid is 1, and rsp_c and rsp_id are held stable until rsp_ready.
- REQ-028: On RESP handshake: ptr = (rsp_id+1) mod NREQ, done_cnt increments, next state is IDLE.
- REQ-029: done_cnt wraps from 0xFFFF to 0x0000.
- REQ-030: eng_a, eng_b and eng_sel hold their values from the handshake until the next grant; they are not cleared at completion.
- REQ-031: Changes on req_* lines outside the IDLE handshake cycle are ignored.
- REQ-032: Back-to-back: the earliest next grant is in the cycle after the RESP handshake, so the minimum operation period is LATENCY+3 cycles.
- REQ-033: A requester that drops req_valid before it is granted is skipped, with no side effect.

Reset
- REQ-034: rst low at a rising edge forces: state IDLE, ptr 0, counter 0, done_cnt 0, and eng_a, eng_b, eng_sel, eng_load, rsp_valid, rsp_id and rsp_c all 0.
- REQ-035: Reset in any state, including mid-WAIT, abandons the operation; no rsp_valid is produced for it and done_cnt does not increment.
- REQ-036: rsp_c and done_cnt first become non-zero after reset only through a completed operation.

Verification (LATENCY=4, NREQ=4)
- REQ-037: Single op: req_valid=0001 in cycle 0, rsp_ready=1 → req_ready=0001 in cycle 0, eng_load in cycle 1, rsp_valid in cycle 6 with rsp_id=0, rsp_c equal to the eng_c value at the end of cycle 5, done_cnt=1.
- REQ-038: Round-robin: req_valid=1111 held high → grant order 0,1,2,3,0, with each grant LATENCY+3=7 cycles apart.
- REQ-039: Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_c and rsp_id stable; req_ready stays 0000 and eng_load stays 0.
- REQ-040: Reset mid-WAIT: rst=0 two cycles after eng_load → next cycle all outputs 0 and state IDLE; a subsequent req_valid=0100 is granted at once, with ptr 0 having no blocking effect.
- REQ-041: Counter wrap: preload done_cnt to 0xFFFF via 65535 ops (or a force) → next completion sets done_cnt to 0x0000.
- REQ-042: sel passthrough: requester 2 with req_sel=1 → eng_sel=1 from the cycle after grant through RESP.
